// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: INIT/RUN state type, NOP encoding, 11-entry boot image and
// boot_word() lookup (returns 0 beyond the image).
package imem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_t;

  localparam int unsigned NOP_WORD  = 0;
  localparam int unsigned BOOT_SIZE = 11;

  // Ascending range so that element 0 is the first word of the image.
  localparam logic [0:BOOT_SIZE-1][7:0] BOOT_IMAGE = {
    8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D, 8'h3D,
    8'h19, 8'h00, 8'h05, 8'h0A, 8'h0F
  };

  function automatic logic [7:0] boot_word(input int unsigned i);
    logic [7:0] w;
    w = 8'h00;
    if (i < BOOT_SIZE) w = BOOT_IMAGE[i[3:0]];
    return w;
  endfunction

endpackage

// File: rtl/imem_init_seq.sv
// Post-reset initialisation sequencer: walks init_ptr over every word, then
// Latency: DEPTH cycles of INIT after reset deasserts, ready on the next cycle.
// Backpressure: none; ready gates fetch/load in the parent.
// Ports: clk, reset (sync, active-high); init_we/init_addr drive the parent's
// write mux during INIT; ready is high in RUN.
module imem_init_seq
  import imem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  imem_state_t       state, state_nxt;
  logic [ADDR_W-1:0] init_ptr, init_ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    init_we      = 1'b0;
    ready        = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_ptr == LAST_ADDR) state_nxt = ST_RUN;
        else                       init_ptr_nxt = init_ptr + 1'b1;
      end
      ST_RUN: begin
        ready = 1'b1;
      end
    endcase
  end

  assign init_addr = init_ptr;

endmodule

// File: rtl/imem.sv
// Synchronous instruction memory with registered fetch, program-load port,
// Latency: fetch_req at edge N -> fetch_valid/instruction at edge N+1; loads
// Backpressure: none; requests are dropped while ready is low (INIT).
// Ports: clk, reset (sync, active-high), ready; fetch_req/fetch_addr ->
// fetch_valid/instruction/addr_err; load_en/load_addr/load_data -> load_err.
// Build option: define IMEM_BOOT_IMAGE_EN to initialise from the boot image,
// otherwise every word initialises to 0.
module imem_sync
  import imem_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ready,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               addr_err,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];

  logic               init_we;
  logic [ADDR_W-1:0]  init_addr;
  logic [INSTR_W-1:0] init_data;
  logic               fetch_in_range, load_in_range;
  logic               fetch_go, load_go;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [INSTR_W-1:0] wr_data;

  imem_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

`ifdef IMEM_BOOT_IMAGE_EN
  assign init_data = INSTR_W'(boot_word(32'(init_addr)));
`else
  assign init_data = '0;
`endif

  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_LIM);
  assign load_in_range  = ({1'b0, load_addr}  < DEPTH_LIM);
  assign fetch_go       = ready & fetch_req;
  assign load_go        = ready & load_en;

  // Write mux: the sequencer owns the array during INIT, the load port in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (init_we) begin
      wr_en   = 1'b1;
      wr_idx  = init_addr[IDX_W-1:0];
      wr_data = init_data;
    end else if (load_go && load_in_range) begin
      wr_en   = 1'b1;
      wr_idx  = load_addr[IDX_W-1:0];
      wr_data = load_data;
    end
  end

  // Storage has no reset; INIT rewrites every word instead.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_idx] <= wr_data;
  end

  // The read samples mem before this edge's write lands, giving
  // read-before-write for a same-address load and fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      instruction <= '0;
      addr_err    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      fetch_valid <= fetch_go;
      addr_err    <= fetch_go & ~fetch_in_range;
      load_err    <= load_go & ~load_in_range;
      if (fetch_go) begin
        instruction <= fetch_in_range ? mem[fetch_addr[IDX_W-1:0]]
                                      : INSTR_W'(NOP_WORD);
      end
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: default instance (8-bit, 32 words) and a
// 16-bit, 11-word instance, checked against an array-based reference model.
// Latency: n/a. Backpressure: n/a.
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready, fetch_req, fetch_valid, addr_err, load_en, load_err;
  logic [7:0]  fetch_addr, instruction, load_addr, load_data;

  logic        s_ready, s_fetch_req, s_fetch_valid, s_addr_err, s_load_err;
  logic [7:0]  s_fetch_addr;
  logic [15:0] s_instruction;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [32];
  logic [7:0] exp_instr;

  localparam logic [7:0] BOOT [11] = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D,
                                       8'h3D, 8'h19, 8'h00, 8'h05, 8'h0A, 8'h0F};

  always #5 clk = ~clk;

  imem_sync u_dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .instruction (instruction),
    .addr_err    (addr_err),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_err    (load_err)
  );

  imem_sync #(.INSTR_W(16), .DEPTH(11), .ADDR_W(8)) u_dut11 (
    .clk         (clk),
    .reset       (reset),
    .ready       (s_ready),
    .fetch_req   (s_fetch_req),
    .fetch_addr  (s_fetch_addr),
    .fetch_valid (s_fetch_valid),
    .instruction (s_instruction),
    .addr_err    (s_addr_err),
    .load_en     (1'b0),
    .load_addr   (8'h00),
    .load_data   (16'h0000),
    .load_err    (s_load_err)
  );

  function automatic logic [7:0] init_val(input int i);
`ifdef IMEM_BOOT_IMAGE_EN
    return (i < 11) ? BOOT[i] : 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < 32; i++) model[i] = init_val(i);
    exp_instr = 8'h00;
  endtask

  // Run INIT with requests held high; they must be ignored. Checks the exact
  // number of not-ready cycles for both instances.
  task automatic wait_init();
    int n_main, n_small;
    n_main = 0; n_small = 0;
    fetch_req = 1'b1; fetch_addr = 8'd3; load_en = 1'b1; load_data = 8'hEE;
    for (int c = 1; c <= 100; c++) begin
      load_addr = c[0] ? 8'd0 : 8'd40;
      step();
      if (n_small == 0 && s_ready) n_small = c;
      check("init_fetch_valid", 32'(fetch_valid), 0);
      check("init_load_err", 32'(load_err), 0);
      if (ready) begin
        n_main = c;
        break;
      end
    end
    fetch_req = 1'b0; load_en = 1'b0;
    check("ready_latency_d32", n_main, 32);
    check("ready_latency_d11", n_small, 11);
  endtask

  // One RUN cycle on the main instance, checked against the model.
  task automatic do_cycle(input logic fr, input logic [7:0] fa,
                          input logic le, input logic [7:0] la, input logic [7:0] ld);
    logic exp_ae, exp_le;
    fetch_req = fr; fetch_addr = fa; load_en = le; load_addr = la; load_data = ld;
    exp_ae = fr && (fa >= 8'd32);
    exp_le = le && (la >= 8'd32);
    if (fr) exp_instr = (fa < 8'd32) ? model[fa[4:0]] : 8'h00;
    if (le && la < 8'd32) model[la[4:0]] = ld;
    step();
    fetch_req = 1'b0; load_en = 1'b0;
    check("ready", 32'(ready), 1);
    check("fetch_valid", 32'(fetch_valid), 32'(fr));
    check("instruction", 32'(instruction), 32'(exp_instr));
    check("addr_err", 32'(addr_err), 32'(exp_ae));
    check("load_err", 32'(load_err), 32'(exp_le));
  endtask

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = 8'h00; load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    s_fetch_req = 1'b0; s_fetch_addr = 8'h00;
    model_init();
    step(); step();
    check("rst_ready", 32'(ready), 0);
    check("rst_fetch_valid", 32'(fetch_valid), 0);
    check("rst_instruction", 32'(instruction), 0);
    check("rst_addr_err", 32'(addr_err), 0);
    check("rst_load_err", 32'(load_err), 0);
    reset = 1'b0;
    wait_init();

    // 16-bit, 11-word instance: gapless stream over all words, then one past the end.
    for (int i = 0; i <= 11; i++) begin
      s_fetch_req = 1'b1; s_fetch_addr = 8'(i);
      step();
      check("d11_valid", 32'(s_fetch_valid), 1);
      check("d11_instr", 32'(s_instruction), (i < 11) ? 32'(init_val(i)) : 0);
      check("d11_addr_err", 32'(s_addr_err), (i == 11) ? 1 : 0);
    end
    s_fetch_req = 1'b0;
    step();
    check("d11_valid_idle", 32'(s_fetch_valid), 0);
    check("d11_load_err", 32'(s_load_err), 0);

    // Initial content and hold behaviour.
    do_cycle(1'b1, 8'd3, 1'b0, 8'd0, 8'd0);
`ifdef IMEM_BOOT_IMAGE_EN
    check("fetch3_const", 32'(instruction), 32'h A9);
`else
    check("fetch3_const", 32'(instruction), 32'h00);
`endif
    do_cycle(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    do_cycle(1'b1, 8'd0, 1'b0, 8'd0, 8'd0);

    // Load then fetch.
    do_cycle(1'b0, 8'd0, 1'b1, 8'd7, 8'h5A);
    do_cycle(1'b1, 8'd7, 1'b0, 8'd0, 8'd0);
    check("load7_const", 32'(instruction), 32'h5A);

    // Same-cycle load and fetch to one address returns the old word.
    do_cycle(1'b0, 8'd0, 1'b1, 8'd4, 8'h4D);
    do_cycle(1'b1, 8'd4, 1'b1, 8'd4, 8'h33);
    check("rbw_old_const", 32'(instruction), 32'h4D);
    do_cycle(1'b1, 8'd4, 1'b0, 8'd0, 8'd0);
    check("rbw_new_const", 32'(instruction), 32'h33);

    // Boundary: address == DEPTH is an error, not an alias.
    do_cycle(1'b1, 8'd32, 1'b0, 8'd0, 8'd0);
    check("oor_fetch_err_const", 32'(addr_err), 1);
    do_cycle(1'b0, 8'd0, 1'b1, 8'd40, 8'h77);
    check("oor_load_err_const", 32'(load_err), 1);
    do_cycle(1'b0, 8'd0, 1'b1, 8'd32, 8'h66);
    do_cycle(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 32; i++) do_cycle(1'b1, 8'(i), 1'b0, 8'd0, 8'd0);

    // Random traffic with frequent same-address collisions.
    for (int c = 0; c < 400; c++) begin
      logic fr, le;
      logic [7:0] fa, la;
      fr = 1'($urandom_range(0, 1));
      fa = 8'($urandom_range(0, 47));
      le = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 4) == 0) ? fa : 8'($urandom_range(0, 47));
      do_cycle(fr, fa, le, la, 8'($urandom));
    end

    // Mid-stream reset discards loaded words.
    do_cycle(1'b0, 8'd0, 1'b1, 8'd0, 8'hFF);
    do_cycle(1'b1, 8'd0, 1'b0, 8'd0, 8'd0);
    check("pre_reset_ff", 32'(instruction), 32'hFF);
    reset = 1'b1;
    step();
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_instruction", 32'(instruction), 0);
    check("mid_rst_fetch_valid", 32'(fetch_valid), 0);
    reset = 1'b0;
    model_init();
    wait_init();
    do_cycle(1'b1, 8'd0, 1'b0, 8'd0, 8'd0);
    check("post_reset_addr0", 32'(instruction), 32'(init_val(0)));
    for (int i = 0; i < 32; i++) do_cycle(1'b1, 8'(i), 1'b0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised, clocked instruction memory that replaces the fixed 8-bit combinational ROM in the fetch path.
- Adds a registered fetch with a request/valid handshake and a program-load write port.
- Adds a post-reset initialisation sequencer and out-of-range detection.
- Sits between the PC/fetch stage and the decoder. The load port is driven by the bench or a boot loader.

Parameters:
- INSTR_W, 8, instruction word width in bits (>= 8)
- DEPTH, 32, number of instruction words (>= 2, need not be a power of 2)
- ADDR_W, 8, width of fetch_addr and load_addr; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ready  out  1  high once initialisation is complete; fetch and load accepted only when high
- fetch_req  in  1  fetch request, sampled on rising clk
- fetch_addr  in  ADDR_W  word address of the fetch
- fetch_valid  out  1  one-cycle pulse; instruction is valid this cycle
- instruction  out  INSTR_W  fetched word, held until the next fetch_valid
- addr_err  out  1  one-cycle pulse with fetch_valid when the fetch address was >= DEPTH
- load_en  in  1  write strobe
- load_addr  in  ADDR_W  write word address
- load_data  in  INSTR_W  write data
- load_err  out  1  one-cycle pulse, cycle after a load_en with load_addr >= DEPTH

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (reset).
- Reset values: ready=0, fetch_valid=0, instruction=0, addr_err=0, load_err=0. FSM goes to INIT with init_ptr=0.
- Reset has priority over everything. Asserting reset mid-INIT or mid-RUN restarts INIT from address 0. Memory contents are rewritten.

FSM:
- INIT: writes the init word to mem[init_ptr] and increments init_ptr each cycle. After writing DEPTH-1, moves to RUN. ready rises on the first RUN cycle, so ready is low for exactly DEPTH cycles after reset deasserts.
- RUN: stays until reset.
- In INIT, fetch_req and load_en are ignored: no fetch_valid, no write, no load_err.

Fetch (RUN):
- fetch_req high at edge N gives fetch_valid=1 at edge N+1, so latency is 1 cycle.
- Back-to-back requests give back-to-back valids with no bubbles.
- fetch_addr < DEPTH: instruction = mem[fetch_addr].
- fetch_addr >= DEPTH: instruction = 0 (NOP) and addr_err=1.
- With no request, fetch_valid=0 and instruction holds its last value.

Load (RUN):
- load_en at edge N writes mem[load_addr] at that edge.
- Out-of-range load is dropped and load_err pulses at N+1.
- A load and a fetch to the same address in the same cycle return the OLD word (read-before-write). The new word is visible from the next fetch.
- Simultaneous load and fetch to different addresses are both serviced.

Widths:
- Address compare is unsigned, full ADDR_W bits.
- No address wrap-around: an address equal to DEPTH is an error, not an alias of 0.

Optional Feature:
- Macro: IMEM_BOOT_IMAGE_EN.
- Defined: the INIT word for address i comes from a built-in boot image (8-bit values, zero-extended to INSTR_W): 0x49, 0xC1, 0x18, 0xA9, 0x4D, 0x3D, 0x19, 0x00, 0x05, 0x0A, 0x0F for addresses 0-10. All other addresses are 0x00. Entries at addresses >= DEPTH are discarded.
- Undefined: INIT writes 0 to every word. The program must be loaded through the load port before use.

Decomposition:
- Shared package imem_pkg holds:
  - FSM state typedef (INIT, RUN)
  - NOP encoding constant (0)
  - 11-entry boot image constant array
  - function boot_word(i) returning the entry or 0
- One natural sub-module: imem_init_seq, containing the init_ptr counter, INIT/RUN FSM and ready generation. It feeds a write-mux in front of the storage array.

Test Plan:
- Reset release, DEPTH=32: ready stays 0 for 32 cycles, then goes 1. Fetch addr 3 returns 0x00 (macro off) or 0xA9 (macro on), 1 cycle after request.
- Load 0x5A to addr 7, then fetch 7 next cycle: fetch_valid pulses with instruction=0x5A, addr_err=0.
- Same-cycle load 0x33 and fetch at addr 4 (prior content 0x4D): returns 0x4D. Re-fetch of addr 4 returns 0x33.
- Fetch addr 32 with DEPTH=32: instruction=0x00 with addr_err=1. Load addr 40: load_err pulses and no memory word changes.
- Assert reset for 1 cycle mid-stream after loading 0xFF to addr 0: ready drops, fetch ignored during INIT. After INIT, addr 0 reads the init value (0x00 or 0x49), not 0xFF.
- INSTR_W=16, DEPTH=11, macro on: streaming fetches of addresses 0-10 on consecutive cycles return 0x0049 through 0x000F with no gaps in fetch_valid.
